// File: rtl/pipe_exec_lane.sv
// Execute/writeback lane: regfile, DEPTH-stage pipe, full forwarding, MUL interlock; issue->wb in DEPTH-1 cycles.
// hold freezes every stage and drops issue_ready; flush kills S1..S(D-1) plus the issuing op.
module pipe_exec_lane #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int DEPTH  = 3,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [AW-1:0]     issue_rs,
  input  logic [AW-1:0]     issue_rt,
  input  logic [AW-1:0]     issue_rd,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic              issue_useimm,
  input  logic              hold,
  input  logic              flush,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  typedef struct packed {
    logic              vld;
    logic              mul;
    logic [2:0]        alu;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
  } stage_t;

  stage_t            r_st      [1:DEPTH];
  stage_t            w_nxt     [1:DEPTH];
  logic [DATA_W-1:0] r_rf      [NREGS];
  logic [DATA_W-1:0] w_fwd_val [1:DEPTH];
  logic              w_fwd_ok  [1:DEPTH];
  logic [DATA_W-1:0] w_alu1;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb_rf;
  logic [DATA_W-1:0] w_opb;
  logic              w_dep;
  logic              w_accept;

  function automatic logic [DATA_W-1:0] f_alu(input logic [2:0] ctrl,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    case (ctrl)
      3'b010:  f_alu = a + b;
      3'b110:  f_alu = a - b;
      3'b000:  f_alu = a & b;
      3'b001:  f_alu = a | b;
      3'b111:  f_alu = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: f_alu = '0;
    endcase
  endfunction

  assign w_alu1 = f_alu(r_st[1].alu, r_st[1].a, r_st[1].b);

  // A MUL only has a real result once it sits in SD.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      w_fwd_val[k] = (k == 1) ? w_alu1 : r_st[k].res;
      w_fwd_ok[k]  = r_st[k].vld && (r_st[k].rd != '0) && (!r_st[k].mul || k == DEPTH);
    end
  end

  // Walk oldest to youngest so the youngest matching producer wins.
  always_comb begin
    w_opa    = (issue_rs == '0) ? '0 : r_rf[issue_rs];
    w_opb_rf = (issue_rt == '0) ? '0 : r_rf[issue_rt];
    w_dep    = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (w_fwd_ok[k] && issue_rs != '0 && r_st[k].rd == issue_rs) w_opa = w_fwd_val[k];
      if (w_fwd_ok[k] && issue_rt != '0 && r_st[k].rd == issue_rt) w_opb_rf = w_fwd_val[k];
      if (k < DEPTH && r_st[k].vld && r_st[k].mul && r_st[k].rd != '0 &&
          (r_st[k].rd == issue_rs || (!issue_useimm && r_st[k].rd == issue_rt)))
        w_dep = 1'b1;
    end
    w_opb = issue_useimm ? issue_imm : w_opb_rf;
  end

  assign issue_ready = !hold && !(issue_valid && w_dep);
  assign w_accept    = issue_valid && issue_ready && !flush;

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) w_nxt[k] = '0;
    if (w_accept) begin
      w_nxt[1].vld = 1'b1;
      w_nxt[1].mul = issue_op[3];
      w_nxt[1].alu = issue_op[2:0];
      w_nxt[1].rd  = issue_rd;
      w_nxt[1].a   = w_opa;
      w_nxt[1].b   = w_opb;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      w_nxt[k] = r_st[k-1];
      if (k == 2) w_nxt[k].res = w_alu1;
      if (k == DEPTH && r_st[k-1].mul) w_nxt[k].res = r_st[k-1].a * r_st[k-1].b;
      if (flush) w_nxt[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) r_st[k] <= '0;
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (!hold) begin
      for (int k = 1; k <= DEPTH; k++) r_st[k] <= w_nxt[k];
      if (r_st[DEPTH].vld && r_st[DEPTH].rd != '0) r_rf[r_st[DEPTH].rd] <= r_st[DEPTH].res;
    end else if (flush) begin
      for (int k = 1; k < DEPTH; k++) r_st[k] <= '0;
    end
  end

  assign wb_valid = r_st[DEPTH].vld;
  assign wb_addr  = r_st[DEPTH].rd;
  assign wb_data  = r_st[DEPTH].res;

endmodule

// File: tb/tb_pipe_exec_lane.sv
// Bench for pipe_exec_lane: directed corner sequences, an ALU vector table, and random traffic
// checked against an in-order architectural model with an in-flight op list.
module tb_pipe_exec_lane;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int D  = 3;
  localparam int AW = 5;
  localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_AND = 4'b0000, OP_OR = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0111, OP_MUL = 4'b1000, OP_BAD = 4'b0011;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_ready, issue_useimm, hold, flush;
  logic [3:0]    issue_op;
  logic [AW-1:0] issue_rs, issue_rt, issue_rd;
  logic [DW-1:0] issue_imm;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  always #5 clk = ~clk;

  pipe_exec_lane #(.DATA_W(DW), .NREGS(NR), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_imm(issue_imm), .issue_useimm(issue_useimm),
    .hold(hold), .flush(flush),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit last_rdy;

  // Model: committed registers plus in-flight ops in program order, each with its pipe age.
  typedef struct { logic [AW-1:0] rd; logic [DW-1:0] res; bit mul; int stage; } ent_t;
  ent_t          q[$];
  logic [DW-1:0] arch [NR];

  typedef struct { logic [3:0] op; logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] exp; } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] r);
    if (r == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].rd == r) return q[i].res;
    return arch[r];
  endfunction

  function automatic logic [DW-1:0] model_exec(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    longint p;
    if (op[3]) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p[DW-1:0];
    end
    case (op[2:0])
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  task automatic check_wb();
    bit ev;
    ev = (q.size() > 0) && (q[0].stage == D);
    chk("wb_valid", DW'(wb_valid), DW'(ev));
    if (ev) begin
      chk("wb_addr", DW'(wb_addr), DW'(q[0].rd));
      chk("wb_data", wb_data, q[0].res);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input int v, input logic [3:0] op, input int rs, input int rt, input int rd,
                      input logic [DW-1:0] imm, input int ui, input int h, input int f);
    bit stall, exp_rdy, acc;
    logic [AW-1:0] s, t, dd;
    logic [DW-1:0] a, b, res;
    ent_t keep[$];
    ent_t e;
    s = AW'(rs); t = AW'(rt); dd = AW'(rd);
    issue_valid = (v != 0); issue_op = op; issue_rs = s; issue_rt = t; issue_rd = dd;
    issue_imm = imm; issue_useimm = (ui != 0); hold = (h != 0); flush = (f != 0);
    stall = 0;
    foreach (q[i])
      if (q[i].mul && q[i].stage < D && q[i].rd != 0 && (q[i].rd == s || (ui == 0 && q[i].rd == t)))
        stall = 1;
    exp_rdy = (h == 0) && !((v != 0) && stall);
    #1;
    last_rdy = issue_ready;
    chk("issue_ready", DW'(issue_ready), DW'(exp_rdy));
    acc = (v != 0) && exp_rdy && (f == 0);
    a = rd_val(s);
    b = (ui != 0) ? imm : rd_val(t);
    res = model_exec(op, a, b);
    @(posedge clk);
    if (h == 0 && q.size() > 0 && q[0].stage == D) begin
      if (q[0].rd != 0) arch[q[0].rd] = q[0].res;
      void'(q.pop_front());
    end
    if (f != 0) begin
      foreach (q[i]) if (q[i].stage == D) keep.push_back(q[i]);
      q = keep;
    end
    if (h == 0) foreach (q[i]) q[i].stage++;
    if (acc) begin
      e.rd = dd; e.res = res; e.mul = op[3]; e.stage = 1;
      q.push_back(e);
    end
    #1;
    check_wb();
  endtask

  task automatic idle();
    step(0, OP_ADD, 0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset_mid();
    issue_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_wb_valid", DW'(wb_valid), '0);
    chk("rst_wb_addr", DW'(wb_addr), '0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_issue_ready", DW'(issue_ready), 32'd1);
    q.delete();
    foreach (arch[i]) arch[i] = '0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int stalls;
    bit done;
    tbl[0]  = '{OP_ADD, 32'd5,         32'd7,         32'd12};
    tbl[1]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0};
    tbl[2]  = '{OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE};
    tbl[3]  = '{OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0};
    tbl[4]  = '{OP_OR,  32'h0000_F000, 32'h0000_000F, 32'h0000_F00F};
    tbl[5]  = '{OP_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1};
    tbl[6]  = '{OP_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0};
    tbl[7]  = '{OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
    tbl[8]  = '{OP_BAD, 32'd5,         32'd7,         32'd0};
    tbl[9]  = '{OP_MUL, 32'd5,         32'd5,         32'd25};
    tbl[10] = '{OP_MUL, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB};
    tbl[11] = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0};
    tbl[12] = '{OP_SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF};

    reset = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_rs = '0; issue_rt = '0; issue_rd = '0;
    issue_imm = '0; issue_useimm = 1'b0; hold = 1'b0; flush = 1'b0;
    foreach (arch[i]) arch[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_valid", DW'(wb_valid), '0);
    chk("reset_wb_addr", DW'(wb_addr), '0);
    chk("reset_wb_data", wb_data, '0);
    chk("reset_issue_ready", DW'(issue_ready), 32'd1);
    reset = 1'b0;

    // r1 = 5, then r2 = r1 + r1 back to back through S1 forwarding.
    step(1, OP_ADD, 0, 0, 1, 32'd5, 1, 0, 0);
    step(1, OP_ADD, 1, 1, 2, '0, 0, 0, 0);
    repeat (D - 2) idle();
    chk("t1_wb_addr", DW'(wb_addr), 32'd1);
    chk("t1_wb_data", wb_data, 32'd5);
    idle();
    chk("t2_wb_addr", DW'(wb_addr), 32'd2);
    chk("t2_wb_data", wb_data, 32'd10);
    repeat (D) idle();

    // MUL consumer must wait D-1 cycles.
    step(1, OP_MUL, 1, 1, 3, '0, 0, 0, 0);
    stalls = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step(1, OP_ADD, 3, 0, 4, '0, 0, 0, 0);
      if (last_rdy) done = 1; else stalls++;
    end
    chk("t3_consumer_issued", DW'(done), 32'd1);
    chk("t3_stall_cycles", DW'(stalls), DW'(D - 1));
    repeat (D - 1) idle();
    chk("t3_wb_addr", DW'(wb_addr), 32'd4);
    chk("t3_wb_data", wb_data, 32'd25);
    repeat (D) idle();

    // hold with SD occupied, then retire once.
    step(1, OP_ADD, 0, 0, 10, 32'd77, 1, 0, 0);
    repeat (D - 1) idle();
    chk("t4_sd_valid", DW'(wb_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, OP_ADD, 10, 0, 11, '0, 0, 1, 0);
      chk("t4_hold_valid", DW'(wb_valid), 32'd1);
      chk("t4_hold_data", wb_data, 32'd77);
    end
    idle();
    chk("t4_release_valid", DW'(wb_valid), '0);
    step(1, OP_ADD, 10, 10, 11, '0, 0, 0, 0);
    repeat (D - 1) idle();
    chk("t4_r10_twice", wb_data, 32'd154);
    repeat (D) idle();

    // flush with younger ops in flight: only the SD op retires.
    step(1, OP_ADD, 0, 0, 7, 32'd1, 1, 0, 0);
    step(1, OP_ADD, 0, 0, 8, 32'd2, 1, 0, 0);
    repeat (D) idle();
    step(1, OP_ADD, 0, 0, 6, 32'd11, 1, 0, 0);
    repeat (D - 3) idle();
    step(1, OP_ADD, 0, 0, 7, 32'd22, 1, 0, 0);
    step(1, OP_ADD, 0, 0, 8, 32'd33, 1, 0, 0);
    chk("t5_sd_addr", DW'(wb_addr), 32'd6);
    step(1, OP_ADD, 0, 0, 9, 32'd44, 1, 0, 1);
    chk("t5_after_flush", DW'(wb_valid), '0);
    repeat (D) idle();
    step(1, OP_ADD, 7, 8, 9, '0, 0, 0, 0);
    step(1, OP_OR, 6, 0, 12, '0, 0, 0, 0);
    repeat (D - 2) idle();
    chk("t5_old_values", wb_data, 32'd3);
    idle();
    chk("t5_sd_retired", wb_data, 32'd11);
    repeat (D) idle();

    // reset with three ops in flight.
    step(1, OP_ADD, 0, 0, 1, 32'd9, 1, 0, 0);
    step(1, OP_SUB, 1, 0, 2, 32'd3, 1, 0, 0);
    step(1, OP_MUL, 2, 2, 3, '0, 0, 0, 0);
    do_reset_mid();
    for (int r = 1; r < NR; r++) step(1, OP_OR, r, 0, r, '0, 0, 0, 0);
    repeat (D) idle();
    step(1, OP_ADD, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0);
    step(1, OP_SLT, 1, 0, 5, 32'd1, 1, 0, 0);
    repeat (D - 1) idle();
    chk("t6_slt_addr", DW'(wb_addr), 32'd5);
    chk("t6_slt_data", wb_data, 32'd1);
    repeat (D) idle();

    foreach (tbl[i]) begin
      step(1, OP_ADD, 0, 0, 1, tbl[i].a, 1, 0, 0);
      step(1, tbl[i].op, 1, 0, 2, tbl[i].b, 1, 0, 0);
      repeat (D - 1) idle();
      chk($sformatf("vec%0d_addr", i), DW'(wb_addr), 32'd2);
      chk($sformatf("vec%0d_data", i), wb_data, tbl[i].exp);
      idle();
    end

    for (int c = 0; c < 1500; c++) begin
      int sel, rs, rt, rd;
      logic [3:0] op;
      logic [DW-1:0] imm;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 9: op = OP_ADD;
        2:       op = OP_SUB;
        3:       op = OP_AND;
        4:       op = OP_OR;
        5:       op = OP_SLT;
        6, 7:    op = OP_MUL;
        default: op = OP_BAD;
      endcase
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 3);
      rt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 3);
      rd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 3);
      imm = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 15)) - 32'd8);
      if ($urandom_range(0, 499) == 0) do_reset_mid();
      else step(($urandom_range(0, 9) < 7) ? 1 : 0, op, rs, rt, rd, imm,
                ($urandom_range(0, 4) < 2) ? 1 : 0,
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 19) == 0) ? 1 : 0);
    end
    repeat (D + 1) idle();
    for (int r = 1; r < NR; r++) step(1, OP_OR, r, 0, r, '0, 0, 0, 0);
    repeat (D + 1) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
